// File: rtl/picomem_dma.sv
// PicoMem word-copy DMA: a responder port for programming, an initiator port for read-then-write beats.
// Define PICOMEM_DMA_IRQ_EN to drive irq from DONE && IRQ_EN; otherwise irq is tied low.
module picomem_dma #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [3:0]  cfg_wstrb,
  output logic [31:0] cfg_rdata,
  output logic        dma_valid,
  input  logic        dma_ready,
  output logic [31:0] dma_addr,
  output logic [31:0] dma_wdata,
  output logic [3:0]  dma_wstrb,
  input  logic [31:0] dma_rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t state, state_nxt;

  logic [31:0]      src_reg, dst_reg, src_w, dst_w, buffer;
  logic [LEN_W-1:0] len_reg, cnt;
  logic             busy, done, irq_en, abort_pend, gap;
  logic             start_go, zero_done, finish, aborting;
  logic             access, wr_en, ctrl_wr, start_req, abort_req, done_w1c, beat_done;
  logic [31:0]      rd_val, len_merged;
  logic             unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[i*8 +: 8] = strb[i] ? wdata[i*8 +: 8] : old[i*8 +: 8];
    return res;
  endfunction

  assign access     = cfg_valid && !cfg_ready;
  assign wr_en      = access && (cfg_wstrb != 4'b0000);
  assign ctrl_wr    = wr_en && (cfg_addr[3:2] == 2'd3) && cfg_wstrb[0];
  assign start_req  = ctrl_wr && cfg_wdata[0];
  assign done_w1c   = ctrl_wr && cfg_wdata[2];
  assign abort_req  = ctrl_wr && cfg_wdata[4];
  assign beat_done  = (state != IDLE) && !gap && dma_ready;
  assign len_merged = merge(32'(len_reg), cfg_wdata, cfg_wstrb);
  assign unused_bits = ^{cfg_addr[31:4], cfg_addr[1:0], len_merged};

  always_comb begin
    rd_val = '0;
    case (cfg_addr[3:2])
      2'd0:    rd_val = src_reg;
      2'd1:    rd_val = dst_reg;
      2'd2:    rd_val = 32'(len_reg);
      default: rd_val = {27'b0, 1'b0, irq_en, done, busy, 1'b0};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus outputs come straight from the state; the gap flag forces the mandatory idle cycle between beats.
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    zero_done = 1'b0;
    finish    = 1'b0;
    aborting  = 1'b0;
    dma_valid = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    dma_wstrb = 4'h0;
    unique case (state)
      IDLE: begin
        if (start_req) begin
          if (len_reg != '0) begin
            start_go  = 1'b1;
            state_nxt = RD;
          end else begin
            zero_done = 1'b1;
          end
        end
      end
      RD: begin
        dma_valid = !gap;
        dma_addr  = src_w;
        if (gap) begin
          if (abort_pend) begin
            aborting  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (dma_ready) begin
          if (abort_pend) begin
            aborting  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WR;
          end
        end
      end
      WR: begin
        dma_valid = !gap;
        dma_addr  = dst_w;
        dma_wdata = buffer;
        dma_wstrb = 4'hF;
        if (gap) begin
          if (abort_pend) begin
            aborting  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (dma_ready) begin
          if (cnt == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else if (abort_pend) begin
            aborting  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Programming registers, status bits and the working copies used by the transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ready  <= 1'b0;
      cfg_rdata  <= '0;
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
      abort_pend <= 1'b0;
      gap        <= 1'b0;
      src_w      <= '0;
      dst_w      <= '0;
      cnt        <= '0;
      buffer     <= '0;
    end else begin
      cfg_ready <= access;
      if (access) cfg_rdata <= rd_val;
      if (wr_en && !busy) begin
        case (cfg_addr[3:2])
          2'd0:    src_reg <= merge(src_reg, cfg_wdata, cfg_wstrb) & 32'hFFFF_FFFC;
          2'd1:    dst_reg <= merge(dst_reg, cfg_wdata, cfg_wstrb) & 32'hFFFF_FFFC;
          2'd2:    len_reg <= len_merged[LEN_W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en <= cfg_wdata[3];
      if (start_go)                busy <= 1'b1;
      else if (finish || aborting) busy <= 1'b0;
      if (finish || zero_done)       done <= 1'b1;
      else if (start_go || done_w1c) done <= 1'b0;
      if (state_nxt == IDLE)      abort_pend <= 1'b0;
      else if (abort_req && busy) abort_pend <= 1'b1;
      gap <= beat_done && (state_nxt != IDLE);
      if (start_go) begin
        src_w <= src_reg;
        dst_w <= dst_reg;
        cnt   <= len_reg;
      end
      if (beat_done && state == RD) buffer <= dma_rdata;
      if (beat_done && state == WR) begin
        src_w <= src_w + 32'd4;
        dst_w <= dst_w + 32'd4;
        cnt   <= cnt - 1'b1;
      end
    end
  end

`ifdef PICOMEM_DMA_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= done && irq_en;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_picomem_dma.sv
// Randomized bench for picomem_dma: a memory target model answers the initiator port and
// every transfer is compared against the beat list implied by SRC/DST/LEN.
module tb_picomem_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
  logic [3:0]  cfg_wstrb;
  logic        dma_valid, dma_ready;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_wstrb;
  logic        irq;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } beat_t;

  beat_t got_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wait_lo = 0;
  int wait_hi = 0;
  int rd_started = 0;
  int first_valid_cyc = -1;
  int last_hs_cyc = 0;

  picomem_dma #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_wstrb(cfg_wstrb), .cfg_rdata(cfg_rdata),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb), .dma_rdata(dma_rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by reads: a fixed scramble of the address.
  function automatic logic [31:0] rdModel(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cfgAccess(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    cfg_wstrb = strb;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_ready && n < 20);
    if (!cfg_ready) checkOutput("cfg_ready_timeout", cfg_ready, 1);
    rd = cfg_rdata;
    cfg_valid = 1'b0;
    cfg_wstrb = 4'h0;
  endtask

  task automatic cfgWriteStrb(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] dummy;
    cfgAccess(addr, data, strb, dummy);
  endtask

  task automatic cfgWrite(input logic [31:0] addr, input logic [31:0] data);
    cfgWriteStrb(addr, data, 4'hF);
  endtask

  task automatic cfgRead(input logic [31:0] addr, output logic [31:0] rd);
    cfgAccess(addr, 32'h0, 4'h0, rd);
  endtask

  task automatic waitIdle(output logic [31:0] ctrl);
    int n = 0;
    do begin
      cfgRead(32'hC, ctrl);
      n++;
    end while (ctrl[1] && n < 400);
    if (ctrl[1]) checkOutput("idle_timeout", ctrl[1], 0);
  endtask

  // Expected traffic: read src+4i then write that word to dst+4i, addresses wrapping at 2^32.
  task automatic compareBeats(input logic [31:0] s, input logic [31:0] d, input int len);
    checkOutput("beat_count", got_q.size(), 2 * len);
    for (int i = 0; i < len && 2 * i + 1 < got_q.size(); i++) begin
      logic [31:0] sa;
      logic [31:0] da;
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      checkOutput("rd_addr", got_q[2*i].addr, sa);
      checkOutput("rd_wstrb", 32'(got_q[2*i].wstrb), 0);
      checkOutput("wr_addr", got_q[2*i+1].addr, da);
      checkOutput("wr_wstrb", 32'(got_q[2*i+1].wstrb), 32'hF);
      checkOutput("wr_data", got_q[2*i+1].wdata, rdModel(sa));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input int lo, input int hi);
    logic [31:0] v;
    logic [31:0] s_al;
    logic [31:0] d_al;
    s_al = src & 32'hFFFF_FFFC;
    d_al = dst & 32'hFFFF_FFFC;
    wait_lo = lo;
    wait_hi = hi;
    got_q.delete();
    first_valid_cyc = -1;
    cfgWrite(32'h0, src);
    cfgWrite(32'h4, dst);
    cfgWrite(32'h8, ($urandom << 16) | 32'(len));
    cfgRead(32'h0, v);
    checkOutput("src_align", v, s_al);
    cfgRead(32'h4, v);
    checkOutput("dst_align", v, d_al);
    cfgRead(32'h8, v);
    checkOutput("len_read", v, 32'(len));
    cfgWrite(32'hC, 32'h1);
    waitIdle(v);
    checkOutput("ctrl_done", v, 32'h4);
    compareBeats(s_al, d_al, len);
    cfgRead(32'h0, v);
    checkOutput("src_kept", v, s_al);
  endtask

  // Memory target: random wait states, hold checks while stalled, gap check after each handshake.
  initial begin
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_wstrb;
    int          waits_left;
    bit          in_beat;
    bit          expect_gap;
    in_beat    = 1'b0;
    expect_gap = 1'b0;
    waits_left = 0;
    dma_ready  = 1'b0;
    dma_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_beat    = 1'b0;
        expect_gap = 1'b0;
        dma_ready  = 1'b0;
        continue;
      end
      if (expect_gap) begin
        checkOutput("gap", dma_valid, 0);
        expect_gap = 1'b0;
      end
      if (dma_valid) begin
        if (!in_beat) begin
          in_beat    = 1'b1;
          hold_addr  = dma_addr;
          hold_wdata = dma_wdata;
          hold_wstrb = dma_wstrb;
          waits_left = $urandom_range(wait_hi, wait_lo);
          if (dma_wstrb == 4'h0) rd_started++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
          checkOutput("hold_addr", dma_addr, hold_addr);
          checkOutput("hold_wstrb", 32'(dma_wstrb), 32'(hold_wstrb));
          if (hold_wstrb != 4'h0) checkOutput("hold_wdata", dma_wdata, hold_wdata);
        end
        if (waits_left == 0) begin
          dma_ready  = 1'b1;
          dma_rdata  = rdModel(dma_addr);
          got_q.push_back('{addr: dma_addr, wdata: dma_wdata, wstrb: dma_wstrb});
          last_hs_cyc = cyc;
          in_beat    = 1'b0;
          expect_gap = 1'b1;
        end else begin
          dma_ready  = 1'b0;
          dma_rdata  = $urandom;
          waits_left--;
        end
      end else begin
        if (in_beat) begin
          checkOutput("valid_drop", dma_valid, 1);
          in_beat = 1'b0;
        end
        dma_ready = 1'($urandom_range(0, 1));
        dma_rdata = $urandom;
      end
    end
  end

  initial begin
    logic [31:0] v;
    int n;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    cfg_wstrb = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cfg_ready", cfg_ready, 0);
    checkOutput("rst_cfg_rdata", cfg_rdata, 0);
    checkOutput("rst_dma_valid", dma_valid, 0);
    checkOutput("rst_dma_addr", dma_addr, 0);
    checkOutput("rst_dma_wdata", dma_wdata, 0);
    checkOutput("rst_dma_wstrb", 32'(dma_wstrb), 0);
    checkOutput("rst_irq", irq, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfgRead(32'(4 * i), v);
      checkOutput("rst_reg", v, 0);
    end

    $display("[TB] basic zero-wait copy");
    wait_lo = 0;
    wait_hi = 0;
    got_q.delete();
    first_valid_cyc = -1;
    cfgWrite(32'h0, 32'h100);
    cfgWrite(32'h4, 32'h200);
    cfgWrite(32'h8, 32'h3);
    cfgWrite(32'hC, 32'h1);
    @(negedge clk);
    checkOutput("ready_pulse", cfg_ready, 0);
    cfgRead(32'hC, v);
    checkOutput("busy_mid", v, 32'h2);
    waitIdle(v);
    checkOutput("done_basic", v, 32'h4);
    checkOutput("zero_wait_span", 32'(last_hs_cyc - first_valid_cyc), 32'd10);
    compareBeats(32'h100, 32'h200, 3);

    $display("[TB] stalled target and random transfers");
    applyStimulus(32'h0000_1000, 32'h0000_2000, 3, 5, 5);
    for (int t = 0; t < 5; t++) applyStimulus($urandom, $urandom, $urandom_range(1, 6), 0, 3);
    applyStimulus(32'hFFFF_FFF8, 32'h0000_3001, 3, 0, 1);
    applyStimulus(32'h0000_0040, 32'h0000_0080, 0, 0, 0);

    $display("[TB] byte strobes");
    cfgWrite(32'h0, 32'h1122_3344);
    cfgWriteStrb(32'h0, 32'hAABB_CCDD, 4'b0101);
    cfgRead(32'h0, v);
    checkOutput("src_strobe", v, 32'h11BB_33DC);
    cfgWrite(32'h8, 32'h0000_1234);
    cfgWriteStrb(32'h8, 32'hFFFF_FFFF, 4'b0010);
    cfgRead(32'h8, v);
    checkOutput("len_strobe", v, 32'h0000_FF34);

    $display("[TB] writes while busy");
    wait_lo = 4;
    wait_hi = 4;
    got_q.delete();
    cfgWrite(32'h0, 32'h500);
    cfgWrite(32'h4, 32'h600);
    cfgWrite(32'h8, 32'h4);
    cfgWrite(32'hC, 32'h1);
    cfgWrite(32'h0, 32'hDEAD_0000);
    cfgWrite(32'h8, 32'h9);
    cfgWrite(32'hC, 32'h1);
    cfgRead(32'h0, v);
    checkOutput("busy_src_kept", v, 32'h500);
    cfgRead(32'h8, v);
    checkOutput("busy_len_kept", v, 32'h4);
    cfgRead(32'hC, v);
    checkOutput("busy_ctrl", v, 32'h2);
    waitIdle(v);
    checkOutput("busy_done", v, 32'h4);
    compareBeats(32'h500, 32'h600, 4);

    $display("[TB] abort during second read");
    wait_lo = 6;
    wait_hi = 6;
    got_q.delete();
    rd_started = 0;
    cfgWrite(32'h0, 32'h700);
    cfgWrite(32'h4, 32'h800);
    cfgWrite(32'h8, 32'd10);
    cfgWrite(32'hC, 32'h1);
    n = 0;
    while (rd_started < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reach", 32'(rd_started >= 2), 1);
    cfgWrite(32'hC, 32'h10);
    waitIdle(v);
    checkOutput("abort_ctrl", v, 32'h0);
    repeat (20) @(negedge clk);
    checkOutput("abort_beats", got_q.size(), 3);
    checkOutput("abort_valid", dma_valid, 0);
    if (got_q.size() >= 3) begin
      checkOutput("abort_wr0", got_q[1].addr, 32'h800);
      checkOutput("abort_rd1", got_q[2].addr, 32'h704);
      checkOutput("abort_rd1_wstrb", 32'(got_q[2].wstrb), 0);
    end

    $display("[TB] interrupt");
    wait_lo = 0;
    wait_hi = 0;
    got_q.delete();
    cfgWrite(32'h0, 32'h900);
    cfgWrite(32'h4, 32'hA00);
    cfgWrite(32'h8, 32'h1);
    cfgWrite(32'hC, 32'h9);
    waitIdle(v);
    checkOutput("irq_ctrl", v, 32'hC);
    @(negedge clk);
`ifdef PICOMEM_DMA_IRQ_EN
    checkOutput("irq_set", irq, 1);
`else
    checkOutput("irq_tied", irq, 0);
`endif
    cfgWrite(32'hC, 32'hC);
    @(negedge clk);
    checkOutput("irq_clear", irq, 0);
    cfgRead(32'hC, v);
    checkOutput("irq_en_kept", v, 32'h8);
    compareBeats(32'h900, 32'hA00, 1);

    $display("[TB] reset mid-transfer");
    wait_lo = 2;
    wait_hi = 2;
    cfgWrite(32'h0, 32'hB00);
    cfgWrite(32'h4, 32'hC00);
    cfgWrite(32'h8, 32'h5);
    cfgWrite(32'hC, 32'h1);
    n = 0;
    while (!dma_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_mid_active", dma_valid, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_valid", dma_valid, 0);
    checkOutput("rst_mid_addr", dma_addr, 0);
    checkOutput("rst_mid_wstrb", 32'(dma_wstrb), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfgRead(32'(4 * i), v);
      checkOutput("rst_mid_reg", v, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/picomem_dma.md
Name: picomem_dma

Overview:
- Word-copy DMA engine for the PicoMem SoC fabric.
- A PicoMem responder port lets the CPU program source, destination and length.
- A PicoMem initiator port then performs read-then-write word transfers, as a second bus master beside picorv32 (behind a master arbiter).
- Reports busy/done status; optional interrupt output.

Parameters:
- LEN_W, 16, width of the word-count register (max transfer 2^LEN_W-1 words)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  responder: request valid
- cfg_ready  out  1  responder: request accepted/complete
- cfg_addr  in  32  responder: byte address, bits [3:2] decoded
- cfg_wdata  in  32  responder: write data
- cfg_wstrb  in  4  responder: byte strobes (0 = read)
- cfg_rdata  out  32  responder: read data
- dma_valid  out  1  initiator: request valid
- dma_ready  in  1  initiator: target ready
- dma_addr  out  32  initiator: word-aligned address
- dma_wdata  out  32  initiator: write data
- dma_wstrb  out  4  initiator: 4'b0000 read, 4'b1111 write
- dma_rdata  in  32  initiator: read data
- irq  out  1  level interrupt (only with PICOMEM_DMA_IRQ_EN; else tied 0)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: cfg_ready=0, cfg_rdata=0, dma_valid=0, dma_addr=0, dma_wdata=0, dma_wstrb=0, irq=0. All registers 0; FSM in IDLE.
- Register map (cfg_addr[3:2]):
  - 0 SRC
  - 1 DST
  - 2 LEN, low LEN_W bits; upper bits read 0
  - 3 CTRL: bit0 START (W1, reads 0), bit1 BUSY (RO), bit2 DONE (W1C), bit3 IRQ_EN, bit4 ABORT (W1, reads 0)
- Address alignment: SRC/DST bits [1:0] are forced to 0 on write.
- Byte strobes: a register write updates only the bytes whose wstrb bit is set.
- Responder timing: cfg_ready pulses high for exactly 1 cycle, 1 cycle after cfg_valid is seen with cfg_ready low. cfg_rdata is valid in that same cycle. Back-to-back accesses therefore take 2 cycles each.
- While BUSY=1: writes to SRC/DST/LEN are ignored (still acknowledged); START is ignored.
- FSM states: IDLE, RD, WR.
  - IDLE: START with LEN!=0 → BUSY=1, DONE=0; working copies src/dst/cnt are loaded from SRC/DST/LEN → RD. START with LEN==0 → DONE=1 immediately, no bus traffic.
  - RD: dma_valid=1, dma_addr=src, dma_wstrb=0. On dma_valid&&dma_ready: capture dma_rdata into buffer, drop dma_valid for 1 cycle → WR.
  - WR: dma_valid=1, dma_addr=dst, dma_wdata=buffer, dma_wstrb=4'hF. On handshake: src+=4, dst+=4, cnt-=1. If cnt becomes 0 → IDLE with BUSY=0, DONE=1; else → RD (after the 1-cycle gap).
- Bus rules:
  - dma_valid never drops and dma_addr/wdata/wstrb never change until dma_ready is seen. dma_ready while dma_valid=0 is ignored.
  - Minimum 1-cycle valid-low gap between beats.
  - Zero-wait target: 4 cycles per word.
- Address arithmetic: modulo 2^32; 0xFFFFFFFC + 4 wraps to 0. SRC/DST registers are not modified by a transfer (working copies only).
- ABORT: written while busy, it is latched. The in-flight beat completes its handshake; the FSM then goes to IDLE with BUSY=0 and DONE=0, and no further beats are issued. ABORT while idle has no effect.
- DONE is set on the same edge that BUSY clears.
- DONE set and W1C in the same cycle: set wins.
- Reset mid-transfer: dma_valid drops asynchronously and all state clears.

Optional Feature:
- PICOMEM_DMA_IRQ_EN defined: irq = DONE && IRQ_EN, registered; it deasserts the cycle after DONE is cleared by W1C.
- Not defined: irq is tied 0. IRQ_EN still reads/writes as a plain storage bit.

Test Plan:
- Program SRC=0x100, DST=0x200, LEN=3, START → 3 reads from 0x100/104/108 and 3 writes of the same data to 0x200/204/208. BUSY=1 throughout, then DONE=1. Zero-wait target gives 12 cycles from first dma_valid to DONE.
- Target holds dma_ready low 5 cycles on each beat → dma_valid/addr/wdata stable throughout; copied data correct.
- LEN=0, START → DONE=1 the next cycle; dma_valid never asserts.
- SRC=0xFFFFFFF8, LEN=3 → read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. SRC register still reads 0xFFFFFFF8.
- LEN=10, ABORT written during the 2nd read beat → that beat and its paired write are not both required. Exactly the in-flight handshake completes, then idle with BUSY=0, DONE=0, and no further dma_valid.
- With PICOMEM_DMA_IRQ_EN, IRQ_EN=1, LEN=1 → irq rises after completion; W1C DONE → irq=0 the next cycle. Also assert reset mid-transfer → dma_valid=0 asynchronously; registers read 0.
